key_cmd_decoder: RTL and testbench



---
 rtl/tank_pkg.sv | 28 ++
 rtl/key_cmd_decoder_if.sv | 13 +
 rtl/key_cmd_decoder_fire_ctrl.sv | 66 ++++++
 rtl/key_cmd_decoder.sv | 124 ++++++++++++
 tb/tb_key_cmd_decoder.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank types: movement directions, fire FSM states, HID keycodes
package tank_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic {
        READY = 1'b0,
        HELD  = 1'b1
    } fire_state_t;

    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_ENTER = 8'h28;

endpackage

// File: rtl/key_cmd_decoder_if.sv
// rtl/key_cmd_decoder_if.sv - per-frame tank command bundle from the decoder to the tanks
interface key_cmd_decoder_if;
    import tank_pkg::*;

    dir_t p1_move;
    dir_t p2_move;
    logic p1_fire;
    logic p2_fire;
    logic cmd_strobe;

    modport master (output p1_move, p2_move, p1_fire, p2_fire, cmd_strobe);
    modport slave  (input  p1_move, p2_move, p1_fire, p2_fire, cmd_strobe);
endinterface

// File: rtl/key_cmd_decoder_fire_ctrl.sv
// rtl/key_cmd_decoder_fire_ctrl.sv - per-player fire FSM with frame cooldown
// Optional KEY_AUTOFIRE_EN: re-fire from HELD once the cooldown has expired.
module fire_ctrl
    import tank_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fedge,
    input  logic fire_req,
    output logic fire
);

    localparam int CDW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_FRAMES);

    fire_state_t     state_q, state_d;
    logic [CDW-1:0]  cd_q, cd_d;
    logic            fire_q, fire_d;

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        fire_d  = fire_q;
        if (fedge) begin
            // Cooldown ticks every frame regardless of state; a shot overrides it below
            fire_d = 1'b0;
            cd_d   = (cd_q == '0) ? '0 : cd_q - CDW'(1);
            case (state_q)
                READY: begin
                    if (fire_req && cd_q == '0) begin
                        fire_d  = 1'b1;
                        cd_d    = CD_LOAD;
                        state_d = HELD;
                    end
                end
                HELD: begin
`ifdef KEY_AUTOFIRE_EN
                    if (fire_req && cd_q == '0) begin
                        fire_d = 1'b1;
                        cd_d   = CD_LOAD;
                    end
`endif
                    if (!fire_req) state_d = READY;
                end
                default: state_d = READY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= READY;
            cd_q    <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            fire_q  <= fire_d;
        end
    end

    assign fire = fire_q;

endmodule

// File: rtl/key_cmd_decoder.sv
// rtl/key_cmd_decoder.sv - debounced keycode to frame-aligned per-player tank commands
// Optional KEY_AUTOFIRE_EN (in fire_ctrl): held fire key re-fires after cooldown.
module key_cmd_decoder
    import tank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COOLDOWN_FRAMES = 3
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  keycode,
    input  logic        frame_clk,
    key_cmd_decoder_if.master cmd
);

    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

    logic [7:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    filt_q, filt_d;
    logic          sync1_q, sync2_q, hist_q;
    logic          fedge_q, fedge_d;
    dir_t          p1_move_q, p1_move_d, p2_move_q, p2_move_d;
    logic          strobe_q, strobe_d;

    dir_t          p1_dir, p2_dir;
    logic          p1_fire_req, p2_fire_req;
    logic          p1_fire, p2_fire;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (keycode != cand_q) begin
            cand_d = keycode;
            cnt_d  = '0;
        end else if (cnt_q < DB_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (cnt_q == DB_MAX) filt_d = cand_q;
    end

    always_comb begin
        p1_dir      = NONE;
        p2_dir      = NONE;
        p1_fire_req = 1'b0;
        p2_fire_req = 1'b0;
        case (filt_q)
            KC_W:     p1_dir = UP;
            KC_S:     p1_dir = DOWN;
            KC_A:     p1_dir = LEFT;
            KC_D:     p1_dir = RIGHT;
            KC_SPACE: p1_fire_req = 1'b1;
            KC_UP:    p2_dir = UP;
            KC_DOWN:  p2_dir = DOWN;
            KC_LEFT:  p2_dir = LEFT;
            KC_RIGHT: p2_dir = RIGHT;
            KC_ENTER: p2_fire_req = 1'b1;
            default:  ;
        endcase
    end

    // Edge is registered once more so outputs land three Clk after the synchroniser sees the rise
    always_comb begin
        fedge_d   = sync2_q & ~hist_q;
        p1_move_d = p1_move_q;
        p2_move_d = p2_move_q;
        strobe_d  = fedge_q;
        if (fedge_q) begin
            p1_move_d = p1_dir;
            p2_move_d = p2_dir;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cand_q    <= 8'h00;
            cnt_q     <= '0;
            filt_q    <= 8'h00;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hist_q    <= 1'b0;
            fedge_q   <= 1'b0;
            p1_move_q <= NONE;
            p2_move_q <= NONE;
            strobe_q  <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            sync1_q   <= frame_clk;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            fedge_q   <= fedge_d;
            p1_move_q <= p1_move_d;
            p2_move_q <= p2_move_d;
            strobe_q  <= strobe_d;
        end
    end

    fire_ctrl #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_fire_p1 (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .fedge    (fedge_q),
        .fire_req (p1_fire_req),
        .fire     (p1_fire)
    );

    fire_ctrl #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_fire_p2 (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .fedge    (fedge_q),
        .fire_req (p2_fire_req),
        .fire     (p2_fire)
    );

    assign cmd.p1_move    = p1_move_q;
    assign cmd.p2_move    = p2_move_q;
    assign cmd.p1_fire    = p1_fire;
    assign cmd.p2_fire    = p2_fire;
    assign cmd.cmd_strobe = strobe_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// tb/tb_key_cmd_decoder.sv - directed self-checking bench for key_cmd_decoder
module tb_key_cmd_decoder;
    import tank_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       frame_clk = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    key_cmd_decoder_if cmd_if ();

    key_cmd_decoder #(.DEBOUNCE_CYCLES(4), .COOLDOWN_FRAMES(3)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .keycode   (keycode),
        .frame_clk (frame_clk),
        .cmd       (cmd_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] kc;
        dir_t       m1;
        dir_t       m2;
        logic       f1;
        logic       f2;
    } vec_t;

    vec_t vecs[10];
    int   cool_exp[8];
    int   held_exp[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_key(input logic [7:0] kc);
        @(negedge clk) keycode = kc;
        repeat (10) @(posedge clk);
    endtask

    // Rise sampled at edge k; outputs and strobe must appear at k+3 and hold afterwards
    task automatic do_frame(input string tag, input dir_t m1, input dir_t m2, input int f1, input int f2);
        @(negedge clk) frame_clk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 check({tag, " strobe_early"}, int'(cmd_if.cmd_strobe), 0);
        @(posedge clk);
        #1;
        check({tag, " strobe"}, int'(cmd_if.cmd_strobe), 1);
        check({tag, " p1_move"}, int'(cmd_if.p1_move), int'(m1));
        check({tag, " p2_move"}, int'(cmd_if.p2_move), int'(m2));
        check({tag, " p1_fire"}, int'(cmd_if.p1_fire), f1);
        check({tag, " p2_fire"}, int'(cmd_if.p2_fire), f2);
        @(posedge clk);
        #1;
        check({tag, " strobe_width"}, int'(cmd_if.cmd_strobe), 0);
        check({tag, " p1_hold"}, int'(cmd_if.p1_move), int'(m1));
        @(negedge clk) frame_clk = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        vecs[0] = '{8'h1A, UP,    NONE,  1'b0, 1'b0};
        vecs[1] = '{8'h16, DOWN,  NONE,  1'b0, 1'b0};
        vecs[2] = '{8'h04, LEFT,  NONE,  1'b0, 1'b0};
        vecs[3] = '{8'h07, RIGHT, NONE,  1'b0, 1'b0};
        vecs[4] = '{8'h52, NONE,  UP,    1'b0, 1'b0};
        vecs[5] = '{8'h51, NONE,  DOWN,  1'b0, 1'b0};
        vecs[6] = '{8'h50, NONE,  LEFT,  1'b0, 1'b0};
        vecs[7] = '{8'h4F, NONE,  RIGHT, 1'b0, 1'b0};
        vecs[8] = '{8'h33, NONE,  NONE,  1'b0, 1'b0};
        vecs[9] = '{8'h00, NONE,  NONE,  1'b0, 1'b0};
        cool_exp = '{1, 0, 0, 0, 1, 0, 0, 0};
`ifdef KEY_AUTOFIRE_EN
        held_exp = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
`else
        held_exp = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

        repeat (4) @(posedge clk);
        #1;
        check("reset p1_move", int'(cmd_if.p1_move), 0);
        check("reset p2_move", int'(cmd_if.p2_move), 0);
        check("reset fire", int'({cmd_if.p1_fire, cmd_if.p2_fire}), 0);
        check("reset strobe", int'(cmd_if.cmd_strobe), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            set_key(vecs[i].kc);
            do_frame($sformatf("vec%0d", i), vecs[i].m1, vecs[i].m2, int'(vecs[i].f1), int'(vecs[i].f2));
        end

        // Glitches of 3 and 4 cycles never reach the counter's terminal value
        @(negedge clk) keycode = 8'h04;
        repeat (3) @(posedge clk);
        @(negedge clk) keycode = 8'h00;
        repeat (10) @(posedge clk);
        do_frame("glitch3", NONE, NONE, 0, 0);
        @(negedge clk) keycode = 8'h04;
        repeat (4) @(posedge clk);
        @(negedge clk) keycode = 8'h00;
        repeat (10) @(posedge clk);
        do_frame("glitch4", NONE, NONE, 0, 0);

        for (int i = 0; i < 8; i++) begin
            set_key((i % 2 == 0) ? 8'h2C : 8'h00);
            do_frame($sformatf("cool%0d", i), NONE, NONE, cool_exp[i], 0);
        end

        set_key(8'h28);
        for (int i = 0; i < 10; i++)
            do_frame($sformatf("held%0d", i), NONE, NONE, 0, held_exp[i]);
        set_key(8'h00);
        do_frame("release", NONE, NONE, 0, 0);

        // Shoot then move right, leaving p1 cooldown at 2 when reset hits mid-frame
        set_key(8'h2C);
        do_frame("pre_shot", NONE, NONE, 1, 0);
        set_key(8'h07);
        do_frame("pre_right", RIGHT, NONE, 0, 0);
        @(negedge clk) frame_clk = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst p1_move", int'(cmd_if.p1_move), 0);
        check("rst p1_fire", int'(cmd_if.p1_fire), 0);
        check("rst strobe", int'(cmd_if.cmd_strobe), 0);
        frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        set_key(8'h2C);
        do_frame("post_rst", NONE, NONE, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
